// File: rtl/ram_row_reader.sv
// Burst read engine for a registered-output RAM: issues up to 15 sequential reads
// and streams the returned words through a 4-entry credit-managed FIFO.
module ram_row_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [3:0]            rows,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int DEPTH  = 4;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [3:0]            rem_q, rem_d;
  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]       last_pipe_q, last_pipe_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [DATA_WIDTH:0]   mem_d [DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;

  logic                  issue, issue_last, credit, push, pop, head_last;
  logic [2:0]            occupancy;
  logic [DATA_WIDTH:0]   head;

  // Reads are in flight for two cycles (address cycle, data cycle); both hold a credit.
  assign occupancy = count_q + {2'b0, vld_pipe_q[1]} + {2'b0, vld_pipe_q[2]};
  assign credit    = occupancy < 3'd4;
  assign head      = mem_q[rd_ptr_q];
  assign head_last = head[DATA_WIDTH];
  assign push      = vld_pipe_q[STAGES];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ram_address_q <= '0;
      next_addr_q   <= '0;
      rem_q         <= '0;
      vld_pipe_q    <= '0;
      last_pipe_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      next_addr_q   <= next_addr_d;
      rem_q         <= rem_d;
      vld_pipe_q    <= vld_pipe_d;
      last_pipe_q   <= last_pipe_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    next_addr_d   = next_addr_q;
    rem_d         = rem_q;
    issue         = 1'b0;
    issue_last    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (rows == 4'd0) begin
          state_d = DONE;
        end else begin
          issue         = 1'b1;
          issue_last    = rows == 4'd1;
          ram_address_d = base_addr;
          next_addr_d   = base_addr + ADDR_WIDTH'(1);
          rem_d         = rows - 4'd1;
          state_d       = (rows == 4'd1) ? DRAIN : RUN;
        end
      end
      RUN: if (credit) begin
        issue         = 1'b1;
        issue_last    = rem_q == 4'd1;
        ram_address_d = next_addr_q;
        next_addr_d   = next_addr_q + ADDR_WIDTH'(1);
        rem_d         = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = DRAIN;
      end
      DRAIN: if (pop && head_last) state_d = DONE;
      default: state_d = IDLE;
    endcase

    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], issue};
    last_pipe_d = {last_pipe_q[STAGES-1:1], issue_last};

    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {last_pipe_q[STAGES], ram_q};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b0, push} - {2'b0, pop};
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == DRAIN);
    done        = state_q == DONE;
    ram_address = ram_address_q;
    ram_wren    = 1'b0;
    out_valid   = count_q != 3'd0;
    out_data    = out_valid ? head[DATA_WIDTH-1:0] : '0;
    out_last    = out_valid & head_last;
  end
endmodule

// File: tb/tb_ram_row_reader.sv
// Directed and randomized checks of ram_row_reader against a 512 x 64 registered-read RAM
// model whose word i holds the value i.
module tb_ram_row_reader;
  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [8:0]  base_addr;
  logic [3:0]  rows;
  logic        busy, done, ram_wren, out_valid, out_last;
  logic [8:0]  ram_address;
  logic [63:0] ram_q, out_data;
  logic [63:0] ram [512];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 512; i++) ram[i] = 64'(i);
  always @(posedge clk) ram_q <= ram[ram_address];

  ram_row_reader #(.DATA_WIDTH(64), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .rows(rows),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_wren(ram_wren),
    .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume words from the current cycle until done; rdy_mode 1 randomizes out_ready.
  task automatic collect(input logic [8:0] base, input logic [3:0] nrows, input int rdy_mode);
    int k = 0;
    int dones = 0;
    int cyc = 0;
    logic [8:0] a;
    while (dones == 0 && cyc < 200) begin
      out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wren", ram_wren, 1'b0);
      if (done) dones++;
      else if (out_valid && out_ready) begin
        a = base + 9'(k);
        chk("word_data", out_data, 64'(a));
        chk("word_last", out_last, k == int'(nrows) - 1);
        k++;
      end
      step();
      cyc++;
    end
    chk("done_seen", dones, 1);
    chk("word_count", k, nrows);
    chk("post_done", done, 1'b0);
    chk("post_busy", busy, 1'b0);
    out_ready = 1'b1;
  endtask

  task automatic run_burst(input logic [8:0] base, input logic [3:0] nrows, input int rdy_mode);
    start = 1'b1; base_addr = base; rows = nrows;
    step();
    start = 1'b0;
    collect(base, nrows, rdy_mode);
  endtask

  initial begin
    logic [8:0] wrap_seq [4];
    wrap_seq[0] = 9'h1FE; wrap_seq[1] = 9'h1FF; wrap_seq[2] = 9'h000; wrap_seq[3] = 9'h001;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0; rows = '0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", ram_address, 9'h000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_last", out_last, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic burst: base 0x010, rows 4
    start = 1'b1; base_addr = 9'h010; rows = 4'd4;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) chk("basic_addr", ram_address, 9'h010 + 9'(c - 1));
      chk("basic_valid", out_valid, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) begin
        chk("basic_data", out_data, 64'h10 + 64'(c - 3));
        chk("basic_last", out_last, c == 6);
      end
      chk("basic_done", done, c == 7);
      chk("basic_busy", busy, c <= 6);
      step();
    end

    // Wrap-around: base 0x1FE, rows 4
    start = 1'b1; base_addr = 9'h1FE; rows = 4'd4;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) chk("wrap_addr", ram_address, wrap_seq[c-1]);
      if (c >= 3 && c <= 6) chk("wrap_data", out_data, 64'(wrap_seq[c-3]));
      chk("wrap_done", done, c == 7);
      step();
    end

    // Start pulsed during RUN must not disturb the 3-word burst at 0x020
    start = 1'b1; base_addr = 9'h020; rows = 4'd3;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin start = 1'b1; base_addr = 9'h050; rows = 4'd5; end
      if (c == 3) start = 1'b0;
      #1;
      chk("ign_addr", ram_address, (c <= 3) ? 9'h020 + 9'(c - 1) : 9'h022);
      chk("ign_valid", out_valid, c >= 3 && c <= 5);
      if (c >= 3 && c <= 5) chk("ign_data", out_data, 64'h20 + 64'(c - 3));
      chk("ign_done", done, c == 6);
      step();
    end

    // Zero length: done in cycle 1, no reads, address held at 0x022
    start = 1'b1; base_addr = 9'h0F0; rows = 4'd0;
    step();
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_valid", out_valid, 1'b0);
    chk("zero_addr", ram_address, 9'h022);
    step();
    chk("zero_done2", done, 1'b0);
    chk("zero_valid2", out_valid, 1'b0);
    chk("zero_addr2", ram_address, 9'h022);

    // Backpressure: rows 15 at 0x100, out_ready low cycles 3..12
    start = 1'b1; base_addr = 9'h100; rows = 4'd15;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) out_ready = 1'b0;
      #1;
      if (c >= 3) begin
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_stable", out_data, 64'h100);
        chk("bp_last", out_last, 1'b0);
      end
      if (c >= 4) chk("bp_issued", ram_address, 9'h103);
      chk("bp_done", done, 1'b0);
      step();
    end
    collect(9'h100, 4'd15, 0);

    // Reset in cycle 5 of a rows-10 burst, then a clean rows-2 burst
    start = 1'b1; base_addr = 9'h080; rows = 4'd10;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_addr", ram_address, 9'h000);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 64'h0);
    chk("mid_rst_last", out_last, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    run_burst(9'h0A0, 4'd2, 0);

    // Random bursts with random out_ready
    for (int n = 0; n < 200; n++)
      run_burst(9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_row_reader.md
# ram_row_reader

Streaming read engine that sits directly upstream of the 512 x 64 dual-port RAM read port. On a start command it issues a burst of 1 to 15 consecutive word reads from a base address, absorbs the RAM's one-cycle registered read latency, and presents the words on a valid/ready stream. A 4-entry output FIFO with credit-based issue keeps throughput at one word per cycle when the consumer is ready and stops issuing reads under backpressure.

## Interface

Parameters:
- DATA_WIDTH, 64, RAM word width
- ADDR_WIDTH, 9, RAM address width (2^ADDR_WIDTH words)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; captured with start
- rows  in  4  number of words to read (0..15); captured with start
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- ram_address  out  ADDR_WIDTH  registered address to RAM port A
- ram_wren  out  1  constant 0; this block never writes
- ram_q  in  DATA_WIDTH  RAM port A read data; valid one cycle after the address cycle
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_WIDTH  stream word (FIFO head)
- out_last  out  1  marks the final word of the burst

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE + start: capture base_addr and rows, then go to RUN. If rows==0, go straight to DONE: no reads are issued and out_valid is never asserted.
- RUN: each cycle, issue one read when credit allows. Credit rule: fifo_count + inflight < 4, using registered values. Issuing drives ram_address = captured address for that cycle, then increments the address modulo 2^ADDR_WIDTH (0x1FF wraps to 0x000) and decrements the remaining count. After the last issue, go to DRAIN.
- inflight: 1 for the cycle after an issue, otherwise 0. In that cycle ram_q is written into the FIFO tail, along with a last flag (1 for the final word of the burst).
- FIFO: depth 4, so it never overflows under the credit rule. Pop happens on out_valid & out_ready. Push and pop in the same cycle is legal.
- DRAIN: wait until the handshake of the last-flagged word, then go to DONE.
- DONE: assert done for one cycle, then return to IDLE.
- start is ignored outside IDLE. start in the DONE cycle is also ignored.
- busy = 1 in RUN and DRAIN; busy = 0 in IDLE and DONE.
- ram_address holds its last value when no read is issued.

## Timing

- Reset values: busy 0, done 0, ram_address 0, out_valid 0, out_data 0, out_last 0, FIFO empty, state IDLE.
- Assertion of rst_n low at any time clears all state immediately, including mid-burst. Any in-flight ram_q is discarded. After rst_n rises, the first start is honoured.
- Cycle 0: start sampled. Cycle 1: first address on ram_address, busy = 1. Cycle 2: ram_q valid and pushed into the FIFO. Cycle 3: out_valid = 1. Start-to-first-word latency is 3 cycles.
- With out_ready held high, words k = 0..rows-1 appear in cycles 3+k. out_last is high with word rows-1. done pulses one cycle after that handshake, and busy falls in the same cycle as done.
- out_valid, out_data and out_last stay stable while out_valid & !out_ready.
- After out_ready is low long enough to fill the FIFO, no reads are issued. Issue resumes the cycle after the first pop frees a credit, with no word lost or duplicated.

## Test plan

- Basic burst: base 0x010, rows 4, RAM preloaded with word[i] = i, out_ready = 1. Required: addresses 0x010..0x013 in cycles 1-4; out_data 0x10..0x13 in cycles 3-6; out_last only in cycle 6; done in cycle 7.
- Wrap-around: base 0x1FE, rows 4. Required: address sequence 0x1FE, 0x1FF, 0x000, 0x001; data order matches that sequence.
- Backpressure: rows 15, out_ready low from cycle 3 to cycle 12. Required: at most 4 reads issued before the first pop; all 15 words delivered in order; out_data stable while stalled; done exactly once.
- Zero length and ignored start: rows 0. Required: done in cycle 1, no out_valid, ram_address unchanged. Separately, start pulsed during RUN. Required: no effect on the current burst.
- Reset mid-burst: rst_n low in cycle 5 of a rows-10 burst. Required: all outputs go to reset values immediately. A following rows-2 burst returns only its own 2 words.
- Random out_ready: 200 bursts with random base and rows, scoreboard against a RAM model. Required: no word lost or duplicated, and ram_wren is always 0.
